// File: rtl/vga_timing_rx.sv
// VGA timing receiver: samples h_sync/v_sync/DE on the pixel strobe, rebuilds
// pixel coordinates, measures line/frame geometry and declares lock once
// consecutive frames measure identically.
module vga_timing_rx #(
  parameter int CNT_W       = 11,
  parameter int LOCK_FRAMES = 2,
  parameter bit SYNC_POL    = 1'b0,
  parameter int TIMEOUT     = 4095
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             h_sync,
  input  logic             v_sync,
  input  logic             DE,
  output logic [9:0]       x_pixel,
  output logic [9:0]       y_pixel,
  output logic             pixel_valid,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [9:0]       POS_MAX = 10'h3FF;
  localparam int               TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam int               M_W     = $clog2(LOCK_FRAMES + 1);
  localparam logic [M_W-1:0]   M_LOCK  = M_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // Saturating increment shared by all measurement counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // Input sampling and edge detection
  // ---------------------------------------------------------------------
  logic r_hs_act;
  logic r_vs_act;
  logic r_de;

  logic w_hs_act;
  logic w_vs_act;
  logic w_h_edge;
  logic w_v_edge;
  logic w_de_rise;
  logic w_de_fall;

  // Edges compare the live inputs against the previous sample so that every
  // consequence of a strobe lands on the clock edge that samples it.
  assign w_hs_act  = (h_sync == SYNC_POL);
  assign w_vs_act  = (v_sync == SYNC_POL);
  assign w_h_edge  = pix_en & w_hs_act & ~r_hs_act;
  assign w_v_edge  = pix_en & w_vs_act & ~r_vs_act;
  assign w_de_rise = pix_en & DE & ~r_de;
  assign w_de_fall = pix_en & ~DE & r_de;

  // Remember the previous sampled level of each input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hs_act <= 1'b0;
      r_vs_act <= 1'b0;
      r_de     <= 1'b0;
    end else if (pix_en) begin
      r_hs_act <= w_hs_act;
      r_vs_act <= w_vs_act;
      r_de     <= DE;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel coordinates (independent of lock state)
  // ---------------------------------------------------------------------
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_pix_valid;

  // x restarts on DE rise, y advances on DE fall and restarts on v_sync
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_pix_valid <= 1'b0;
      if (pix_en) begin
        r_pix_valid <= DE;
        if (w_de_rise) begin
          r_x <= '0;
        end else if (DE && (r_x != POS_MAX)) begin
          r_x <= r_x + 1'b1;
        end
        if (w_v_edge) begin
          r_y <= '0;
        end else if (w_de_fall && (r_y != POS_MAX)) begin
          r_y <= r_y + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Line / frame measurement
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_dcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic [CNT_W-1:0] r_vact;
  logic [CNT_W-1:0] r_ref_h;
  logic [CNT_W-1:0] r_ref_ha;
  logic             r_first;
  logic             r_ha_seen;
  logic             r_frame_bad;

  logic [CNT_W-1:0] w_vcnt_n;
  logic [CNT_W-1:0] w_vact_n;
  logic [CNT_W-1:0] w_ref_h_n;
  logic [CNT_W-1:0] w_ref_ha_n;
  logic             w_first_n;
  logic             w_ha_seen_n;
  logic             w_bad_n;
  logic             w_line_has_de;

  assign w_line_has_de = (r_dcnt != '0);

  // Frame state after closing the current line. A frame boundary on the same
  // strobe publishes these values, so the closing line belongs to the ending
  // frame. Active width is referenced against the first line carrying DE;
  // blanking lines only take part in the total-length check.
  always_comb begin
    w_vcnt_n    = r_vcnt;
    w_vact_n    = r_vact;
    w_ref_h_n   = r_ref_h;
    w_ref_ha_n  = r_ref_ha;
    w_first_n   = r_first;
    w_ha_seen_n = r_ha_seen;
    w_bad_n     = r_frame_bad;
    if (w_h_edge) begin
      w_vcnt_n = sat_inc(r_vcnt);
      if (r_first) begin
        w_ref_h_n = r_hcnt;
        w_first_n = 1'b0;
      end else if (r_hcnt != r_ref_h) begin
        w_bad_n = 1'b1;
      end
      if (w_line_has_de) begin
        w_vact_n = sat_inc(r_vact);
        if (!r_ha_seen) begin
          w_ref_ha_n  = r_dcnt;
          w_ha_seen_n = 1'b1;
        end else if (r_dcnt != r_ref_ha) begin
          w_bad_n = 1'b1;
        end
      end
    end
  end

  // Per-line strobe counters; the strobe carrying the h_sync edge opens the next line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hcnt <= '0;
      r_dcnt <= '0;
    end else if (pix_en) begin
      if (w_h_edge) begin
        r_hcnt <= CNT_W'(1);
        r_dcnt <= CNT_W'(DE);
      end else begin
        r_hcnt <= sat_inc(r_hcnt);
        if (DE) begin
          r_dcnt <= sat_inc(r_dcnt);
        end
      end
    end
  end

  // Per-frame accumulators; cleared at each frame boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vcnt      <= '0;
      r_vact      <= '0;
      r_ref_h     <= '0;
      r_ref_ha    <= '0;
      r_first     <= 1'b0;
      r_ha_seen   <= 1'b0;
      r_frame_bad <= 1'b0;
    end else if (pix_en) begin
      if (w_v_edge) begin
        r_vcnt      <= '0;
        r_vact      <= '0;
        r_ref_h     <= w_ref_h_n;
        r_ref_ha    <= '0;
        r_first     <= 1'b1;
        r_ha_seen   <= 1'b0;
        r_frame_bad <= 1'b0;
      end else begin
        r_vcnt      <= w_vcnt_n;
        r_vact      <= w_vact_n;
        r_ref_h     <= w_ref_h_n;
        r_ref_ha    <= w_ref_ha_n;
        r_first     <= w_first_n;
        r_ha_seen   <= w_ha_seen_n;
        r_frame_bad <= w_bad_n;
      end
    end
  end

  // ---------------------------------------------------------------------
  // h_sync watchdog
  // ---------------------------------------------------------------------
  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;

  // Fires exactly once, on the TIMEOUT-th strobe without an h_sync edge
  assign w_timeout = pix_en & ~w_h_edge & (r_to_cnt == TO_LAST);

  // Count strobes since the last h_sync edge, holding at TIMEOUT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (pix_en) begin
      if (w_h_edge) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Lock FSM and published measurements
  // ---------------------------------------------------------------------
  state_t           r_state;
  logic [M_W-1:0]   r_match;
  logic             r_prev_valid;
  logic [CNT_W-1:0] r_prev_ht;
  logic [CNT_W-1:0] r_prev_vt;
  logic [CNT_W-1:0] r_prev_ha;
  logic [CNT_W-1:0] r_prev_va;
  logic [CNT_W-1:0] r_h_total;
  logic [CNT_W-1:0] r_v_total;
  logic [CNT_W-1:0] r_h_active;
  logic [CNT_W-1:0] r_v_active;
  logic             r_locked;
  logic             r_err;
  logic             r_frame_start;

  logic             w_same;
  logic [M_W-1:0]   w_match_inc;

  // A frame matches only if it was clean and all four measurements repeat
  assign w_same = r_prev_valid & ~w_bad_n &
                  (w_ref_h_n  == r_prev_ht) & (w_vcnt_n == r_prev_vt) &
                  (w_ref_ha_n == r_prev_ha) & (w_vact_n == r_prev_va);
  assign w_match_inc = r_match + 1'b1;

  // SEARCH -> TRACK on first boundary, TRACK -> LOCKED after enough matches,
  // LOCKED falls back on a bad frame; the watchdog overrides everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_SEARCH;
      r_match       <= '0;
      r_prev_valid  <= 1'b0;
      r_prev_ht     <= '0;
      r_prev_vt     <= '0;
      r_prev_ha     <= '0;
      r_prev_va     <= '0;
      r_h_total     <= '0;
      r_v_total     <= '0;
      r_h_active    <= '0;
      r_v_active    <= '0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_err         <= 1'b0;
      r_frame_start <= 1'b0;
      if (pix_en) begin
        if (w_v_edge) begin
          r_frame_start <= 1'b1;
        end
        if (w_timeout) begin
          if (r_state == S_LOCKED) begin
            r_err <= 1'b1;
          end
          r_state      <= S_SEARCH;
          r_locked     <= 1'b0;
          r_match      <= '0;
          r_prev_valid <= 1'b0;
        end else if (w_v_edge) begin
          if (r_state == S_SEARCH) begin
            // The partial frame seen so far is discarded
            r_state      <= S_TRACK;
            r_prev_valid <= 1'b0;
            r_match      <= '0;
          end else begin
            r_h_total    <= w_ref_h_n;
            r_h_active   <= w_ref_ha_n;
            r_v_total    <= w_vcnt_n;
            r_v_active   <= w_vact_n;
            r_prev_ht    <= w_ref_h_n;
            r_prev_ha    <= w_ref_ha_n;
            r_prev_vt    <= w_vcnt_n;
            r_prev_va    <= w_vact_n;
            r_prev_valid <= 1'b1;
            if (r_state == S_TRACK) begin
              if (w_same) begin
                r_match <= w_match_inc;
                if (w_match_inc == M_LOCK) begin
                  r_state  <= S_LOCKED;
                  r_locked <= 1'b1;
                end
              end else begin
                r_match <= '0;
              end
            end else if (!w_same) begin
              r_err    <= 1'b1;
              r_locked <= 1'b0;
              r_state  <= S_TRACK;
              r_match  <= '0;
            end
          end
        end
      end
    end
  end

  assign x_pixel     = r_x;
  assign y_pixel     = r_y;
  assign pixel_valid = r_pix_valid;
  assign frame_start = r_frame_start;
  assign h_total     = r_h_total;
  assign v_total     = r_v_total;
  assign h_active    = r_h_active;
  assign v_active    = r_v_active;
  assign locked      = r_locked;
  assign err         = r_err;

endmodule
